// File: rtl/cpu_pkg.sv
// Shared decode constants for the MIPS pipeline: opcodes, functs,
// ALUOp codes, control-bundle bit positions and the NOP instruction.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALUOP_ADD = 4'd0;
    localparam logic [3:0] ALUOP_SUB = 4'd1;
    localparam logic [3:0] ALUOP_AND = 4'd2;
    localparam logic [3:0] ALUOP_OR  = 4'd3;
    localparam logic [3:0] ALUOP_SLT = 4'd4;

    localparam int CTRL_W        = 12;
    localparam int CTRL_REGWRITE = 11;
    localparam int CTRL_MEMTOREG = 10;
    localparam int CTRL_MEMWRITE = 9;
    localparam int CTRL_MEMREAD  = 8;
    localparam int CTRL_BRANCH   = 7;
    localparam int CTRL_JUMP     = 6;
    localparam int CTRL_REGDST   = 5;
    localparam int CTRL_ALUSRC   = 4;

    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/regfile_2r1w.sv
// 32x32 register file: two combinational reads, one posedge write.
// $0 reads zero. Define STAGE_ID_RF_BYPASS_EN for WB write-through.
// Ports: clk_i, rst_ni, we_i/waddr_i/wdata_i, raddr{a,b}_i -> rdata{a,b}_o
module regfile_2r1w #(
    parameter int RF_DEPTH = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddra_i,
    input  logic [4:0]  raddrb_i,
    output logic [31:0] rdataa_o,
    output logic [31:0] rdatab_o
);

    logic [31:0] mem_q [RF_DEPTH];
    logic        wr_en;

    assign wr_en = we_i && (waddr_i != 5'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RF_DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    function automatic logic [31:0] rd(input logic [4:0] a);
        if (a == 5'd0) return '0;
`ifdef STAGE_ID_RF_BYPASS_EN
        if (wr_en && (a == waddr_i)) return wdata_i;
`endif
        return mem_q[a];
    endfunction

    assign rdataa_o = rd(raddra_i);
    assign rdatab_o = rd(raddrb_i);

endmodule

// File: rtl/stage_id.sv
// ID stage: IF/ID register, register file, control decode, imm/jump
// generation and load-use stall. Optional macro STAGE_ID_RF_BYPASS_EN.
// In: Clk, Clrn, IF_PC4/IF_Inst, MEM_PCSrc, EX_MemRead/EX_Rt, WB_*.
// Out: ID_Stall, IDout_{PC4,RsData,RtData,Imm32,Jtarg,Rs,Rt,Rd,Ctrl}.
module stage_id
    import cpu_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP,
    parameter int          RF_DEPTH = 32
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic [31:0]       IF_PC4,
    input  logic [31:0]       IF_Inst,
    input  logic              MEM_PCSrc,
    input  logic              EX_MemRead,
    input  logic [4:0]        EX_Rt,
    input  logic              WB_RegWrite,
    input  logic [4:0]        WB_WriteReg,
    input  logic [31:0]       WB_WriteData,
    output logic              ID_Stall,
    output logic [31:0]       IDout_PC4,
    output logic [31:0]       IDout_RsData,
    output logic [31:0]       IDout_RtData,
    output logic [31:0]       IDout_Imm32,
    output logic [31:0]       IDout_Jtarg,
    output logic [4:0]        IDout_Rs,
    output logic [4:0]        IDout_Rt,
    output logic [4:0]        IDout_Rd,
    output logic [CTRL_W-1:0] IDout_Ctrl
);

    logic [31:0] pc4_q, pc4_d;
    logic [31:0] inst_q, inst_d;
    logic [5:0]  op, fn;
    logic [CTRL_W-1:0] ctrl;

    assign op = inst_q[31:26];
    assign fn = inst_q[5:0];
    assign IDout_Rs = inst_q[25:21];
    assign IDout_Rt = inst_q[20:16];
    assign IDout_Rd = inst_q[15:11];

    assign ID_Stall = EX_MemRead && (EX_Rt != 5'd0) &&
                      ((EX_Rt == IDout_Rs) || (EX_Rt == IDout_Rt));

    // Flush outranks stall so a redirect never keeps a wrong-path instr.
    always_comb begin
        pc4_d  = IF_PC4;
        inst_d = IF_Inst;
        if (MEM_PCSrc) begin
            pc4_d  = '0;
            inst_d = NOP_INST;
        end else if (ID_Stall) begin
            pc4_d  = pc4_q;
            inst_d = inst_q;
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            pc4_q  <= '0;
            inst_q <= NOP_INST;
        end else begin
            pc4_q  <= pc4_d;
            inst_q <= inst_d;
        end
    end

    regfile_2r1w #(.RF_DEPTH(RF_DEPTH)) u_rf (
        .clk_i    (Clk),
        .rst_ni   (Clrn),
        .we_i     (WB_RegWrite),
        .waddr_i  (WB_WriteReg),
        .wdata_i  (WB_WriteData),
        .raddra_i (IDout_Rs),
        .raddrb_i (IDout_Rt),
        .rdataa_o (IDout_RsData),
        .rdatab_o (IDout_RtData)
    );

    always_comb begin
        ctrl = '0;
        unique case (1'b1)
            (op == OP_RTYPE): begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_REGDST]   = 1'b1;
                unique case (fn)
                    FN_ADD:  ctrl[3:0] = ALUOP_ADD;
                    FN_SUB:  ctrl[3:0] = ALUOP_SUB;
                    FN_AND:  ctrl[3:0] = ALUOP_AND;
                    FN_OR:   ctrl[3:0] = ALUOP_OR;
                    FN_SLT:  ctrl[3:0] = ALUOP_SLT;
                    default: ctrl      = '0;
                endcase
            end
            (op == OP_LW): begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_MEMTOREG] = 1'b1;
                ctrl[CTRL_MEMREAD]  = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
            end
            (op == OP_SW): begin
                ctrl[CTRL_MEMWRITE] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
            end
            (op == OP_BEQ): begin
                ctrl[CTRL_BRANCH] = 1'b1;
                ctrl[3:0]         = ALUOP_SUB;
            end
            (op == OP_J): ctrl[CTRL_JUMP] = 1'b1;
            (op == OP_ADDI): begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
            end
            (op == OP_ORI): begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                ctrl[3:0]           = ALUOP_OR;
            end
            default: ctrl = '0;
        endcase
    end

    // A stalled cycle issues a bubble downstream.
    assign IDout_Ctrl  = ID_Stall ? '0 : ctrl;
    assign IDout_PC4   = pc4_q;
    assign IDout_Imm32 = (op == OP_ORI) ? {16'h0, inst_q[15:0]}
                                        : {{16{inst_q[15]}}, inst_q[15:0]};
    assign IDout_Jtarg = {pc4_q[31:28], inst_q[25:0], 2'b00};

endmodule

// File: doc/stage_id.md
Name: stage_id

Overview:
- Instruction Decode stage of the 5-stage pipelined MIPS CPU, directly downstream of the instruction-fetch stage.
- Contains the IF/ID pipeline register, the 32x32 register file (written by WB), the main control decoder, immediate/jump-target generation and load-use hazard detection.
- Produces the stall that freezes PC and IF/ID, and absorbs the MEM-stage redirect as a flush.

Parameters:
- NOP_INST, 32'h0000_0000, instruction loaded into IF/ID on reset or flush.
- RF_DEPTH, 32, register count; address width fixed at 5.

Ports:
- Clk  in  1  clock, all state updates on posedge.
- Clrn  in  1  asynchronous active-low reset.
- IF_PC4  in  32  PC+4 from the fetch stage.
- IF_Inst  in  32  fetched instruction.
- MEM_PCSrc  in  1  taken branch/jump from MEM; flushes IF/ID.
- EX_MemRead  in  1  instruction currently in EX is a load.
- EX_Rt  in  5  destination register of that load.
- WB_RegWrite  in  1  register-file write enable.
- WB_WriteReg  in  5  write address.
- WB_WriteData  in  32  write data.
- ID_Stall  out  1  hold PC and IF/ID this cycle.
- IDout_PC4  out  32  PC+4 of the decoded instruction.
- IDout_RsData  out  32  register-file read port A.
- IDout_RtData  out  32  register-file read port B.
- IDout_Imm32  out  32  sign- or zero-extended immediate.
- IDout_Jtarg  out  32  {PC4[31:28], inst[25:0], 2'b00}.
- IDout_Rs / IDout_Rt / IDout_Rd  out  5 each  register fields.
- IDout_Ctrl  out  12  {RegWrite, MemtoReg, MemWrite, MemRead, Branch, Jump, RegDst, ALUSrc, ALUOp[3:0]}.

Behaviour:
- Reset (Clrn=0, asynchronous):
  - IF/ID register loads PC4=0 and Inst=NOP_INST.
  - All 32 registers are cleared.
  - All outputs read 0 (NOP decodes to all-zero Ctrl; ID_Stall=0).
- IF/ID register update, on posedge, in priority order:
  - MEM_PCSrc=1: load NOP_INST and PC4=0 (flush). Flush wins over stall.
  - Else ID_Stall=1: hold current contents.
  - Else: load IF_PC4 and IF_Inst.
- Outputs:
  - Combinational from IF/ID plus the register file, so each instruction appears at the outputs one cycle after IF presents it.
  - While ID_Stall=1, IDout_Ctrl is forced to 0 (bubble); data and field outputs are unchanged.
- Hazard detection:
  - ID_Stall = EX_MemRead & (EX_Rt!=0) & ((EX_Rt==inst[25:21]) | (EX_Rt==inst[20:16])).
  - ID_Stall is purely combinational; it lasts exactly one cycle per load-use pair.
- Register file:
  - 2 combinational read ports, 1 write port on posedge when WB_RegWrite=1 and WB_WriteReg!=0.
  - $0 always reads 0; a write to $0 is ignored.
- Decode (opcode inst[31:26]):
  - R-type 0x00 with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt: RegWrite=1, RegDst=1.
  - lw 0x23: RegWrite, MemtoReg, MemRead, ALUSrc.
  - sw 0x2B: MemWrite, ALUSrc.
  - beq 0x04: Branch, ALUOp=sub.
  - j 0x02: Jump.
  - addi 0x08: sign-extended immediate.
  - ori 0x0D: zero-extended immediate.
  - Unknown opcode or funct gives Ctrl=0 (treated as NOP).
- ALUOp encoding (package constants): add=0, sub=1, and=2, or=3, slt=4.
- Imm32 is sign-extended except for ori.

Optional Feature:
- Macro: STAGE_ID_RF_BYPASS_EN.
- Defined: a read whose address equals WB_WriteReg while WB_RegWrite=1 and the address is nonzero returns WB_WriteData in the same cycle (write-through).
- Undefined: the read returns the old register value; software/compiler spacing is then required.

Decomposition:
- Package cpu_pkg holds:
  - opcode and funct localparams,
  - ALUOp codes,
  - Ctrl bit-index constants and CTRL_W=12,
  - the NOP value.
- Sub-module regfile_2r1w holds the register array, the $0 rule and the bypass macro.
- Decoder and hazard logic stay inline.

Test Plan:
- Reset mid-run: Clrn low for 1 ns mid-cycle -> IDout_Ctrl=0 immediately; afterwards reading $5 returns 0.
- WB writes $8=32'hDEAD_BEEF; the next cycle IF_Inst=add $9,$8,$8 (0x01084820) -> IDout_RsData=IDout_RtData=DEADBEEF, Ctrl RegWrite=1, RegDst=1, ALUOp=0.
- Load-use: EX_MemRead=1, EX_Rt=8 with IF/ID holding 0x01084820 -> ID_Stall=1 and Ctrl=0 for one cycle; IF/ID held; the next cycle with EX_MemRead=0, IDout_Ctrl is restored.
- Flush priority: MEM_PCSrc=1 and ID_Stall=1 in the same cycle -> after the posedge IF/ID holds NOP and IDout_PC4=0.
- Immediates: ori $1,$0,0x8000 -> Imm32=32'h0000_8000; addi $1,$0,0x8000 -> Imm32=32'hFFFF_8000.
- Same-cycle write/read of $8:
  - With STAGE_ID_RF_BYPASS_EN: new data is visible.
  - Without it: old data is returned.
  - A write to $0 with data 32'h1234 -> $0 still reads 0.
